alu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational Y86 execute ALU. It adds a registered result, an iterative multiply, and logical and arithmetic shifts. It also owns the architectural condition-code register. It sits in the execute stage and accepts one operation at a time over a valid/ready input channel. It returns the result and flags over a valid/ready output channel.

---
 rtl/alu_seq_if.sv | 35 +++
 rtl/alu_seq.sv | 176 +++++++++++++++++
 tb/tb_alu_seq.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: operation/result channel of the sequential execute ALU.
//   Request side : in_valid_i/in_ready_o handshake, operands aluA_i/aluB_i,
//                  function code fun_i, set_cc_i, synchronous abort flush_i.
//   Response side: out_valid_o/out_ready_i handshake, result e_valE_o,
//                  flags ZF_o/SF_o/OF_o, architectural CC register cc_o.
// The slave modport belongs to the ALU and the master modport to the issuing stage.
interface alu_seq_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned FUN_W  = 4
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] aluA_i;
    logic [DATA_W-1:0] aluB_i;
    logic [FUN_W-1:0]  fun_i;
    logic              set_cc_i;
    logic              flush_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] e_valE_o;
    logic              ZF_o;
    logic              SF_o;
    logic              OF_o;
    logic [2:0]        cc_o;

    modport slave (
        input  in_valid_i, aluA_i, aluB_i, fun_i, set_cc_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, e_valE_o, ZF_o, SF_o, OF_o, cc_o
    );

    modport master (
        output in_valid_i, aluA_i, aluB_i, fun_i, set_cc_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, e_valE_o, ZF_o, SF_o, OF_o, cc_o
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked Y86 execute ALU with registered result, iterative
// shift-add multiply, logical/arithmetic shifts and the architectural CC register.
//   clk_i   : clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : alu_seq_if.slave; accepts one operation at a time and returns the
//             result and flags until the consumer takes them
module alu_seq #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned FUN_W  = 4
) (
    input  logic     clk_i,
    input  logic     rst_n_i,
    alu_seq_if.slave bus
);
    localparam int unsigned ShW = $clog2(DATA_W);

    localparam logic [FUN_W-1:0] FunAdd = FUN_W'(0);
    localparam logic [FUN_W-1:0] FunSub = FUN_W'(1);
    localparam logic [FUN_W-1:0] FunAnd = FUN_W'(2);
    localparam logic [FUN_W-1:0] FunXor = FUN_W'(3);
    localparam logic [FUN_W-1:0] FunMul = FUN_W'(4);
    localparam logic [FUN_W-1:0] FunShl = FUN_W'(5);
    localparam logic [FUN_W-1:0] FunSar = FUN_W'(6);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              zf_q, zf_d;
    logic              sf_q, sf_d;
    logic              of_q, of_d;
    logic [2:0]        cc_q, cc_d;
    logic              set_cc_q, set_cc_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [ShW-1:0]    cnt_q, cnt_d;

    logic              in_ready;
    logic              accept;
    logic [ShW-1:0]    sh_amt;
    logic [DATA_W-1:0] alu_res;
    logic              alu_of;
    logic [DATA_W-1:0] mul_sum;
    logic              a_msb, b_msb;

    // Single-cycle datapath on the live operands; only used on the accept cycle.
    always_comb begin
        sh_amt  = bus.aluA_i[ShW-1:0];
        a_msb   = bus.aluA_i[DATA_W-1];
        b_msb   = bus.aluB_i[DATA_W-1];
        alu_res = '0;
        alu_of  = 1'b0;
        case (bus.fun_i)
            FunAdd: begin
                alu_res = bus.aluB_i + bus.aluA_i;
                alu_of  = (a_msb == b_msb) && (alu_res[DATA_W-1] != a_msb);
            end
            FunSub: begin
                alu_res = bus.aluB_i - bus.aluA_i;
                alu_of  = (a_msb != b_msb) && (alu_res[DATA_W-1] != b_msb);
            end
            FunAnd: alu_res = bus.aluB_i & bus.aluA_i;
            FunXor: alu_res = bus.aluB_i ^ bus.aluA_i;
            FunShl: alu_res = bus.aluB_i << sh_amt;
            FunSar: alu_res = DATA_W'($signed(bus.aluB_i) >>> sh_amt);
            default: alu_res = '0;
        endcase
    end

    assign mul_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        zf_d     = zf_q;
        sf_d     = sf_q;
        of_d     = of_q;
        cc_d     = cc_q;
        set_cc_d = set_cc_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;

        in_ready = !bus.flush_i &&
                   ((state_q == StIdle) || ((state_q == StDone) && bus.out_ready_i));
        accept   = bus.in_valid_i && in_ready;

        if (bus.flush_i) begin
            // Abort wins over both handshakes; CC is never touched by a flushed op.
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: ;
                StMul: begin
                    acc_d    = mul_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 1'b1;
                    // Last partial product folds straight into the result register.
                    if (cnt_q == ShW'(DATA_W - 1)) begin
                        res_d   = mul_sum;
                        zf_d    = (mul_sum == '0);
                        sf_d    = mul_sum[DATA_W-1];
                        of_d    = 1'b0;
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready_i) begin
                        if (set_cc_q) begin
                            cc_d = {zf_q, sf_q, of_q};
                        end
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase

            // A same-cycle accept in DONE overrides the return to IDLE.
            if (accept) begin
                set_cc_d = bus.set_cc_i;
                if (bus.fun_i == FunMul) begin
                    acc_d    = '0;
                    mcand_d  = bus.aluB_i;
                    mplier_d = bus.aluA_i;
                    cnt_d    = '0;
                    state_d  = StMul;
                end else begin
                    res_d   = alu_res;
                    zf_d    = (alu_res == '0);
                    sf_d    = alu_res[DATA_W-1];
                    of_d    = alu_of;
                    state_d = StDone;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= StIdle;
            res_q    <= '0;
            zf_q     <= 1'b1;
            sf_q     <= 1'b0;
            of_q     <= 1'b0;
            cc_q     <= 3'b100;
            set_cc_q <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            zf_q     <= zf_d;
            sf_q     <= sf_d;
            of_q     <= of_d;
            cc_q     <= cc_d;
            set_cc_q <= set_cc_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = (state_q == StDone);
    assign bus.e_valE_o    = res_q;
    assign bus.ZF_o        = zf_q;
    assign bus.SF_o        = sf_q;
    assign bus.OF_o        = of_q;
    assign bus.cc_o        = cc_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq with a behavioural reference model.
module tb_alu_seq;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned FUN_W  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_seq_if #(.DATA_W(DATA_W), .FUN_W(FUN_W)) bus ();

    alu_seq #(.DATA_W(DATA_W), .FUN_W(FUN_W)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [2:0] cc_model = 3'b100;

    typedef struct packed {
        logic [63:0] res;
        logic        zf;
        logic        sf;
        logic        of;
    } ref_t;

    // Reference: signed overflow judged from a sign-extended 65-bit sum/difference.
    function automatic ref_t ref_op(input logic [3:0] fun, input logic [63:0] a,
                                    input logic [63:0] b);
        ref_t r;
        logic [64:0] wide;
        r.of = 1'b0;
        case (fun)
            4'd0: begin
                wide  = {a[63], a} + {b[63], b};
                r.res = wide[63:0];
                r.of  = wide[64] != wide[63];
            end
            4'd1: begin
                wide  = {b[63], b} - {a[63], a};
                r.res = wide[63:0];
                r.of  = wide[64] != wide[63];
            end
            4'd2: r.res = a & b;
            4'd3: r.res = a ^ b;
            4'd4: r.res = a * b;
            4'd5: r.res = b << (a % 64);
            4'd6: r.res = $signed(b) >>> (a % 64);
            default: r.res = 64'd0;
        endcase
        r.zf = (r.res == 64'd0);
        r.sf = r.res[63];
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: v = v & 64'h7;
            1: v = 64'h7FFF_FFFF_FFFF_FFFF;
            2: v = 64'h8000_0000_0000_0000;
            default: ;
        endcase
        return v;
    endfunction

    // Presents one op, scrambles the inputs after acceptance and waits (bounded)
    // for out_valid. lat counts rising edges from the accept edge onward.
    task automatic run_op(input logic [3:0] fun, input logic [63:0] a, input logic [63:0] b,
                          input logic sc, output int lat, output logic ready_seen,
                          output logic accepted);
        @(negedge clk);
        bus.fun_i       = fun;
        bus.aluA_i      = a;
        bus.aluB_i      = b;
        bus.set_cc_i    = sc;
        bus.in_valid_i  = 1'b1;
        bus.out_ready_i = 1'b0;
        accepted = bus.in_ready_o;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        bus.aluA_i     = {$urandom, $urandom};
        bus.aluB_i     = {$urandom, $urandom};
        bus.fun_i      = 4'($urandom);
        bus.set_cc_i   = ~sc;
        lat = 1;
        ready_seen = 1'b0;
        @(negedge clk);
        while (!bus.out_valid_o && lat < 200) begin
            if (bus.in_ready_o) ready_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_out(input logic sc, input ref_t e);
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b0;
        if (sc) cc_model = {e.zf, e.sf, e.of};
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.in_ready_o, bus.out_valid_o, bus.e_valE_o, bus.ZF_o, bus.SF_o, bus.OF_o,
             bus.cc_o} !== {1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 3'b100})
            $display("FAIL reset_state: got rdy=%b vld=%b val=%h z/s/o=%b%b%b cc=%b",
                     bus.in_ready_o, bus.out_valid_o, bus.e_valE_o, bus.ZF_o, bus.SF_o,
                     bus.OF_o, bus.cc_o);
        else n_pass++;
    endtask

    // Op, expected latency and CC behaviour after the handshake.
    task automatic check_op(input string name, input logic [3:0] fun, input logic [63:0] a,
                            input logic [63:0] b, input logic sc);
        ref_t e;
        int lat;
        logic rs, acc;
        e = ref_op(fun, a, b);
        run_op(fun, a, b, sc, lat, rs, acc);
        n_checks++;
        if ({bus.e_valE_o, bus.ZF_o, bus.SF_o, bus.OF_o} !== {e.res, e.zf, e.sf, e.of})
            $display("FAIL %s_result: got %h z/s/o=%b%b%b want %h %b%b%b", name,
                     bus.e_valE_o, bus.ZF_o, bus.SF_o, bus.OF_o, e.res, e.zf, e.sf, e.of);
        else n_pass++;
        n_checks++;
        if ({acc, lat, rs} !== {1'b1, ((fun == 4'd4) ? 65 : 1), 1'b0})
            $display("FAIL %s_timing: got accepted=%b lat=%0d busy_ready=%b want 1 %0d 0",
                     name, acc, lat, rs, (fun == 4'd4) ? 65 : 1);
        else n_pass++;
        take_out(sc, e);
        @(negedge clk);
        n_checks++;
        if ({bus.cc_o, bus.out_valid_o} !== {cc_model, 1'b0})
            $display("FAIL %s_cc: got cc=%b vld=%b want cc=%b vld=0", name, bus.cc_o,
                     bus.out_valid_o, cc_model);
        else n_pass++;
    endtask

    task automatic test_directed();
        check_op("addq_ovf", 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        n_checks++;
        if (bus.cc_o !== 3'b011) $display("FAIL addq_cc_const: got %b want 011", bus.cc_o);
        else n_pass++;
        check_op("subq_zero", 4'd1, 64'd5, 64'd5, 1'b0);
        check_op("mulq_neg", 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1'b1);
        check_op("sarq", 4'd6, 64'd4, 64'h8000_0000_0000_0000, 1'b1);
        check_op("shlq_mod", 4'd5, 64'd65, 64'd1, 1'b0);
        check_op("unknown", 4'd12, 64'd9, 64'd7, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [3:0] f;
            f = 4'($urandom_range(0, 15));
            if (f > 4'd6 && $urandom_range(0, 1) == 0) f = 4'($urandom_range(0, 6));
            check_op("random", f, rnd64(), rnd64(), 1'($urandom));
        end
    endtask

    task automatic test_backpressure();
        ref_t e;
        int lat;
        logic rs, acc;
        e = ref_op(4'd1, 64'd3, 64'd1);
        run_op(4'd1, 64'd3, 64'd1, 1'b1, lat, rs, acc);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({bus.out_valid_o, bus.in_ready_o, bus.e_valE_o, bus.ZF_o, bus.SF_o, bus.OF_o}
                !== {1'b1, 1'b0, e.res, e.zf, e.sf, e.of})
                $display("FAIL backpressure_hold: cyc %0d got vld=%b rdy=%b val=%h want %h",
                         i, bus.out_valid_o, bus.in_ready_o, bus.e_valE_o, e.res);
            else n_pass++;
            @(negedge clk);
        end
        take_out(1'b1, e);
        @(negedge clk);
        n_checks++;
        if (bus.cc_o !== cc_model)
            $display("FAIL backpressure_cc: got %b want %b", bus.cc_o, cc_model);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        ref_t exp_q[$];
        logic sc_q[$];
        int n = 8;
        bus.out_ready_i = 1'b1;
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                if (sc_q[i-2]) cc_model = {exp_q[i-2].zf, exp_q[i-2].sf, exp_q[i-2].of};
            end
            if (i >= 1) begin
                n_checks++;
                if ({bus.out_valid_o, bus.in_ready_o, bus.e_valE_o, bus.ZF_o, bus.SF_o,
                     bus.OF_o, bus.cc_o} !== {1'b1, 1'b1, exp_q[i-1].res, exp_q[i-1].zf,
                     exp_q[i-1].sf, exp_q[i-1].of, cc_model})
                    $display("FAIL b2b_op%0d: got vld=%b rdy=%b val=%h cc=%b want %h cc=%b",
                             i - 1, bus.out_valid_o, bus.in_ready_o, bus.e_valE_o, bus.cc_o,
                             exp_q[i-1].res, cc_model);
                else n_pass++;
            end
            if (i < n) begin
                logic [3:0] f;
                logic [63:0] a, b;
                logic sc;
                f = 4'($urandom_range(0, 15));
                if (f == 4'd4) f = 4'd0;
                a = rnd64();
                b = rnd64();
                sc = 1'($urandom);
                exp_q.push_back(ref_op(f, a, b));
                sc_q.push_back(sc);
                bus.fun_i      = f;
                bus.aluA_i     = a;
                bus.aluB_i     = b;
                bus.set_cc_i   = sc;
                bus.in_valid_i = 1'b1;
            end else begin
                bus.in_valid_i = 1'b0;
            end
        end
        @(negedge clk);
        if (sc_q[n-1]) cc_model = {exp_q[n-1].zf, exp_q[n-1].sf, exp_q[n-1].of};
        bus.out_ready_i = 1'b0;
        n_checks++;
        if ({bus.out_valid_o, bus.cc_o} !== {1'b0, cc_model})
            $display("FAIL b2b_drain: got vld=%b cc=%b want 0 %b", bus.out_valid_o, bus.cc_o,
                     cc_model);
        else n_pass++;
    endtask

    task automatic test_flush();
        logic seen;
        logic [2:0] cc_before;
        cc_before = bus.cc_o;
        @(negedge clk);
        bus.fun_i      = 4'd4;
        bus.aluA_i     = 64'd7;
        bus.aluB_i     = 64'd0;
        bus.set_cc_i   = 1'b1;
        bus.in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        bus.flush_i     = 1'b1;
        bus.out_ready_i = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready_o !== 1'b0)
            $display("FAIL flush_ready_low: got %b want 0", bus.in_ready_o);
        else n_pass++;
        @(posedge clk);
        #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.out_valid_o, bus.in_ready_o} !== 2'b01)
            $display("FAIL flush_to_idle: got vld=%b rdy=%b want 0 1", bus.out_valid_o,
                     bus.in_ready_o);
        else n_pass++;
        seen = 1'b0;
        repeat (70) begin
            @(negedge clk);
            if (bus.out_valid_o) seen = 1'b1;
        end
        bus.out_ready_i = 1'b0;
        n_checks++;
        if ({seen, bus.cc_o} !== {1'b0, cc_before})
            $display("FAIL flush_no_result: got seen=%b cc=%b want 0 %b", seen, bus.cc_o,
                     cc_before);
        else n_pass++;
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        logic rs, acc;
        check_op("pre_reset_add", 4'd0, 64'd1, 64'd1, 1'b1);
        @(negedge clk);
        bus.fun_i      = 4'd4;
        bus.aluA_i     = 64'hFFFF;
        bus.aluB_i     = 64'h1234;
        bus.set_cc_i   = 1'b1;
        bus.in_valid_i = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.in_ready_o, bus.out_valid_o, bus.e_valE_o, bus.ZF_o, bus.SF_o, bus.OF_o,
             bus.cc_o} !== {1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 3'b100})
            $display("FAIL async_reset: got rdy=%b vld=%b val=%h z/s/o=%b%b%b cc=%b",
                     bus.in_ready_o, bus.out_valid_o, bus.e_valE_o, bus.ZF_o, bus.SF_o,
                     bus.OF_o, bus.cc_o);
        else n_pass++;
        cc_model = 3'b100;
        @(negedge clk);
        rst_n = 1'b1;
        check_op("post_reset_xor", 4'd3, 64'hF0, 64'h0F, 1'b1);
        lat = 0;
        rs = 1'b0;
        acc = 1'b0;
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.aluA_i      = '0;
        bus.aluB_i      = '0;
        bus.fun_i       = '0;
        bus.set_cc_i    = 1'b0;
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b0;
        #23;
        rst_n = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
